mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Initiator for the single-pointer 8x256 data memory. Drives its address, write-data and write-enable pins and consumes its combinational read data.
- Performs block copy (src -> dst) or block fill (constant -> dst) of up to 255 bytes on command from the core, then reports completion.
- Sits between the core's control logic and the data memory port. The core does not touch the memory while Busy is high.

Parameters:
- AW, 8, address width; memory depth is 2**AW.
- DW, 8, data width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  command strobe; accepted only in IDLE.
- Mode  in  1  0 = copy, 1 = fill; sampled with Start.
- SrcAddr  in  AW  copy source base; sampled with Start.
- DstAddr  in  AW  destination base; sampled with Start.
- Length  in  AW  byte count, 0..255; sampled with Start.
- FillValue  in  DW  fill constant; sampled with Start.
- Abort  in  1  terminate the transfer in progress.
- MemAddress  out  AW  to memory address pin.
- MemDataIn  out  DW  to memory write-data pin.
- MemWriteEn  out  1  to memory write-enable pin.
- MemDataOut  in  DW  from memory combinational read data.
- Busy  out  1  high in READ and WRITE states.
- Done  out  1  one-cycle completion pulse.
- Remaining  out  AW  bytes not yet written.

Behaviour:
- Reset is asynchronous. While Reset is low:
  - state = IDLE;
  - all pointers, the count and the hold register = 0;
  - MemAddress = 0, MemDataIn = 0, MemWriteEn = 0, Busy = 0, Done = 0, Remaining = 0.
  - Applies mid-transfer too: MemWriteEn drops immediately and no further write occurs.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - On Start=1, latch SrcAddr, DstAddr, Length, Mode and FillValue.
  - Length=0 -> DONE.
  - Otherwise Mode=0 -> READ, Mode=1 -> WRITE.
  - Outputs: MemWriteEn=0, MemAddress=0.
- READ (copy only):
  - MemAddress = src pointer, MemWriteEn = 0.
  - Hold register captures MemDataOut at the clock edge.
  - src pointer increments, wrapping modulo 256 (0xFF -> 0x00).
  - Next state: WRITE.
- WRITE:
  - MemAddress = dst pointer, MemWriteEn = 1.
  - MemDataIn = hold register (copy) or latched FillValue (fill).
  - At the edge: dst pointer increments with wrap; count decrements.
  - If count was 1 -> DONE; else READ (copy) or WRITE (fill).
- DONE:
  - Done = 1 for exactly one cycle, Busy = 0.
  - Next state: IDLE.
  - Start in DONE is ignored; Start is ignored in READ and WRITE as well.
- Throughput:
  - Copy: N bytes take 2N busy cycles.
  - Fill: N bytes take N busy cycles.
  - Done asserts in the cycle after the last write.
  - Start accepted at edge k -> first memory access in cycle k+1.
- MemDataIn outside WRITE: drives the hold register (copy) or FillValue (fill); don't-care to the memory since MemWriteEn=0.
- Abort in READ or WRITE:
  - MemWriteEn forced 0 in that cycle; that cycle's write does not occur.
  - No pointer or count update; next state is DONE.
  - Done pulses normally.
  - Abort in IDLE or DONE has no effect.
  - Abort and Start in the same IDLE cycle: Start wins.
- Remaining = count register.
  - Equals Length after a command is accepted; decrements on each completed write; 0 after normal completion.
  - Holds its value after an Abort until the next accepted Start.
- Overlap:
  - Strictly ascending byte order, read-before-write per byte.
  - Overlapping regions with dst > src replicate source bytes. This is defined behaviour; the engine performs no hazard check.
- Address wrap: a block crossing 0xFF continues at 0x00. No error is flagged.

Test Plan:
- Copy: preload mem[0x10..0x13] = A1, B2, C3, D4; Start with Mode=0, Src=0x10, Dst=0x40, Length=4 -> mem[0x40..0x43] = A1, B2, C3, D4; Busy high for exactly 8 cycles; Done pulses once; Remaining = 0.
- Fill: Mode=1, Dst=0xFE, Length=3, FillValue=0x5A -> writes to 0xFE, 0xFF, 0x00 in 3 consecutive cycles; MemWriteEn high for those 3 cycles only; mem[0x01] unchanged.
- Zero length: Length=0 -> Done the cycle after Start; MemWriteEn never asserted; Busy never asserted.
- Abort: copy with Length=10; assert Abort in the 3rd WRITE cycle -> exactly 2 bytes written; Done pulses; Remaining = 8; next Start is accepted normally.
- Async reset mid-copy: drop Reset during a WRITE cycle -> MemWriteEn = 0 without waiting for a clock edge; that byte is not written; after release, state is IDLE and Busy = 0.
- Start ignored while busy: pulse Start with new arguments during a fill -> original transfer completes unchanged; no second transfer.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Block copy / block fill initiator for a single-port memory with combinational read data.
// One byte per READ+WRITE pair in copy mode, one byte per WRITE cycle in fill mode.
module mem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Mode,
    input  logic [AW-1:0] SrcAddr,
    input  logic [AW-1:0] DstAddr,
    input  logic [AW-1:0] Length,
    input  logic [DW-1:0] FillValue,
    input  logic          Abort,
    output logic [AW-1:0] MemAddress,
    output logic [DW-1:0] MemDataIn,
    output logic          MemWriteEn,
    input  logic [DW-1:0] MemDataOut,
    output logic          Busy,
    output logic          Done,
    output logic [AW-1:0] Remaining
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] hold_q, hold_d;
    logic [DW-1:0] fill_q, fill_d;
    logic          mode_q, mode_d;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            fill_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            fill_q  <= fill_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        fill_d     = fill_q;
        mode_d     = mode_q;
        MemAddress = '0;
        MemWriteEn = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    src_d  = SrcAddr;
                    dst_d  = DstAddr;
                    cnt_d  = Length;
                    mode_d = Mode;
                    fill_d = FillValue;
                    if (Length == '0) begin
                        state_d = DONE;
                    end else if (Mode) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end

            READ: begin
                MemAddress = src_q;
                if (Abort) begin
                    state_d = DONE;
                end else begin
                    hold_d  = MemDataOut;
                    src_d   = src_q + 1'b1;
                    state_d = WRITE;
                end
            end

            WRITE: begin
                MemAddress = dst_q;
                // Abort suppresses the write combinationally so the current byte is never committed.
                if (Abort) begin
                    state_d = DONE;
                end else begin
                    MemWriteEn = 1'b1;
                    dst_d      = dst_q + 1'b1;
                    cnt_d      = cnt_q - 1'b1;
                    if (cnt_q == AW'(1)) begin
                        state_d = DONE;
                    end else if (mode_q) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign MemDataIn = mode_q ? fill_q : hold_q;
    assign Busy      = (state_q == READ) || (state_q == WRITE);
    assign Done      = (state_q == DONE);
    assign Remaining = cnt_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural 256x8 memory and a write scoreboard.
module tb_mem_copy_engine;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic          Mode;
    logic [AW-1:0] SrcAddr;
    logic [AW-1:0] DstAddr;
    logic [AW-1:0] Length;
    logic [DW-1:0] FillValue;
    logic          Abort;
    logic [AW-1:0] MemAddress;
    logic [DW-1:0] MemDataIn;
    logic          MemWriteEn;
    logic [DW-1:0] MemDataOut;
    logic          Busy;
    logic          Done;
    logic [AW-1:0] Remaining;

    mem_copy_engine #(.AW(AW), .DW(DW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Mode       (Mode),
        .SrcAddr    (SrcAddr),
        .DstAddr    (DstAddr),
        .Length     (Length),
        .FillValue  (FillValue),
        .Abort      (Abort),
        .MemAddress (MemAddress),
        .MemDataIn  (MemDataIn),
        .MemWriteEn (MemWriteEn),
        .MemDataOut (MemDataOut),
        .Busy       (Busy),
        .Done       (Done),
        .Remaining  (Remaining)
    );

    always #5 Clk = ~Clk;

    // Memory model: combinational read, write on rising edge; bench preload port takes priority.
    logic [7:0] mem [256];
    logic       pre_we;
    logic [7:0] pre_addr;
    logic [7:0] pre_data;

    assign MemDataOut = mem[MemAddress];

    always @(posedge Clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (MemWriteEn) mem[MemAddress] <= MemDataIn;
    end

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  busy_cnt, done_cnt, we_cnt;

    function automatic logic [7:0] pat(input int i);
        return 8'(i) ^ 8'h33;
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic clr();
        busy_cnt = 0;
        done_cnt = 0;
        we_cnt   = 0;
    endtask

    // One clock cycle: observe at the falling edge, return 1 time unit after the next rising edge.
    task automatic cyc();
        wr_t e;
        @(negedge Clk);
        if (Busy) busy_cnt++;
        if (Done) done_cnt++;
        if (MemWriteEn) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL extra_write: observed write addr %02h data %02h, expected no write",
                       MemAddress, MemDataIn);
            end else begin
                e = exp_q.pop_front();
                check8("wr_addr", MemAddress, e.a);
                check8("wr_data", MemDataIn, e.d);
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge Clk);
        #1;
        pre_we   = 1'b0;
    endtask

    task automatic start(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] len, input logic [7:0] fv);
        Mode      = m;
        SrcAddr   = s;
        DstAddr   = d;
        Length    = len;
        FillValue = fv;
        Start     = 1'b1;
        cyc();
        Start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; Mode = 1'b0; SrcAddr = '0; DstAddr = '0;
        Length = '0; FillValue = '0; Abort = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        clr();

        for (int i = 0; i < 256; i++) poke(8'(i), pat(i));
        poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);

        check8("rst_addr", MemAddress, 8'h00);
        check8("rst_wdata", MemDataIn, 8'h00);
        check1("rst_we", MemWriteEn, 1'b0);
        check1("rst_busy", Busy, 1'b0);
        check1("rst_done", Done, 1'b0);
        check8("rst_remaining", Remaining, 8'h00);
        Reset = 1'b1;
        cyc();

        // Copy 4 bytes 0x10 -> 0x40
        clr();
        push_wr(8'h40, 8'hA1); push_wr(8'h41, 8'hB2); push_wr(8'h42, 8'hC3); push_wr(8'h43, 8'hD4);
        start(1'b0, 8'h10, 8'h40, 8'd4, 8'h00);
        check8("copy_first_addr", MemAddress, 8'h10);
        check8("copy_remaining_start", Remaining, 8'd4);
        wait_done(40);
        cyc(); cyc();
        checkn("copy_busy_cycles", busy_cnt, 8);
        checkn("copy_done_pulses", done_cnt, 1);
        checkn("copy_writes", we_cnt, 4);
        checkn("copy_queue_left", exp_q.size(), 0);
        check8("copy_remaining_end", Remaining, 8'h00);
        check8("copy_mem43", mem[8'h43], 8'hD4);

        // Fill across the top of the address space
        clr();
        push_wr(8'hFE, 8'h5A); push_wr(8'hFF, 8'h5A); push_wr(8'h00, 8'h5A);
        start(1'b1, 8'h00, 8'hFE, 8'd3, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            check1("fill_we_on", MemWriteEn, 1'b1);
            cyc();
        end
        check1("fill_we_off", MemWriteEn, 1'b0);
        check1("fill_done", Done, 1'b1);
        cyc();
        checkn("fill_busy_cycles", busy_cnt, 3);
        checkn("fill_writes", we_cnt, 3);
        check8("fill_mem00", mem[8'h00], 8'h5A);
        check8("fill_mem01_untouched", mem[8'h01], pat(1));

        // Zero length
        clr();
        start(1'b0, 8'h10, 8'h50, 8'd0, 8'h00);
        check1("zero_done", Done, 1'b1);
        check1("zero_busy", Busy, 1'b0);
        check1("zero_we", MemWriteEn, 1'b0);
        cyc();
        check1("zero_done_one_cycle", Done, 1'b0);
        checkn("zero_busy_cycles", busy_cnt, 0);
        checkn("zero_writes", we_cnt, 0);
        checkn("zero_done_pulses", done_cnt, 1);

        // Abort in the third WRITE of a 10-byte copy
        clr();
        push_wr(8'h60, pat(8'h20)); push_wr(8'h61, pat(8'h21));
        start(1'b0, 8'h20, 8'h60, 8'd10, 8'h00);
        for (int i = 0; i < 5; i++) cyc();
        check1("abort_pre_we", MemWriteEn, 1'b1);
        check8("abort_pre_addr", MemAddress, 8'h62);
        Abort = 1'b1;
        #1;
        check1("abort_we_forced_low", MemWriteEn, 1'b0);
        cyc();
        Abort = 1'b0;
        check1("abort_done", Done, 1'b1);
        check8("abort_remaining_done", Remaining, 8'd8);
        cyc();
        check8("abort_remaining_idle", Remaining, 8'd8);
        check8("abort_mem62_untouched", mem[8'h62], pat(8'h62));
        checkn("abort_writes", we_cnt, 2);
        checkn("abort_queue_left", exp_q.size(), 0);
        clr();
        push_wr(8'h70, pat(8'h30));
        start(1'b0, 8'h30, 8'h70, 8'd1, 8'h00);
        wait_done(10);
        cyc();
        checkn("after_abort_done", done_cnt, 1);
        check8("after_abort_mem70", mem[8'h70], pat(8'h30));
        check8("after_abort_remaining", Remaining, 8'h00);

        // Start pulsed during a fill is ignored
        clr();
        for (int i = 0; i < 5; i++) push_wr(8'(8'h80 + i), 8'h3C);
        start(1'b1, 8'h00, 8'h80, 8'd5, 8'h3C);
        cyc();
        Mode = 1'b0; SrcAddr = 8'h10; DstAddr = 8'h90; Length = 8'd2; FillValue = 8'h11;
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        wait_done(20);
        cyc(); cyc(); cyc();
        checkn("busy_start_busy_cycles", busy_cnt, 5);
        checkn("busy_start_done_pulses", done_cnt, 1);
        checkn("busy_start_writes", we_cnt, 5);
        checkn("busy_start_queue_left", exp_q.size(), 0);
        check8("busy_start_mem84", mem[8'h84], 8'h3C);
        check8("busy_start_mem90_untouched", mem[8'h90], pat(8'h90));

        // Asynchronous reset during a WRITE
        clr();
        push_wr(8'hA0, 8'hA1); push_wr(8'hA1, 8'hB2); push_wr(8'hA2, 8'hC3); push_wr(8'hA3, 8'hD4);
        start(1'b0, 8'h10, 8'hA0, 8'd4, 8'h00);
        cyc(); cyc(); cyc();
        check1("arst_pre_we", MemWriteEn, 1'b1);
        check8("arst_pre_addr", MemAddress, 8'hA1);
        #1;
        Reset = 1'b0;
        #1;
        check1("arst_we_immediate", MemWriteEn, 1'b0);
        check1("arst_busy_immediate", Busy, 1'b0);
        check8("arst_remaining", Remaining, 8'h00);
        cyc();
        Reset = 1'b1;
        exp_q.delete();
        cyc();
        check1("arst_busy_after", Busy, 1'b0);
        check1("arst_done_after", Done, 1'b0);
        check8("arst_addr_after", MemAddress, 8'h00);
        check8("arst_memA0", mem[8'hA0], 8'hA1);
        check8("arst_memA1_untouched", mem[8'hA1], pat(8'hA1));
        checkn("arst_writes", we_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
